// File: rtl/fib_seq_gen_if.sv
// Stream and control bundle for fib_seq_gen. The generator side uses the master
// modport and the consumer/controller side uses the slave modport.
interface fib_seq_gen_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 6
);
    logic             start;
    logic [IDX_W-1:0] n_terms;
    logic             abort;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] index;
    logic             last;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        input  start, n_terms, abort, ready,
        output valid, data, index, last, busy, done, overflow
    );

    modport slave (
        output start, n_terms, abort, ready,
        input  valid, data, index, last, busy, done, overflow
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci sequence generator: streams F(0)..F(N-1) over a valid/ready port,
// and stops early, flagging overflow, when the next term would not fit in WIDTH bits.
module fib_seq_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 6
) (
    input logic           clk,
    input logic           rst_n,
    fib_seq_gen_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, a_nxt;
    logic [WIDTH-1:0] b, b_nxt;
    logic             b_ovf, b_ovf_nxt;
    logic [IDX_W-1:0] k, k_nxt;
    logic [IDX_W-1:0] n, n_nxt;
    logic             ovf, ovf_nxt;

    logic [WIDTH:0]   sum;
    logic             at_end;
    logic             is_last;
    logic             fire;

    // a never holds a wrapped value: the run stops as soon as b carries out.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign at_end  = (k == (n - IDX_ONE));
    assign is_last = at_end || b_ovf;
    assign fire    = (state == RUN) && bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= WIDTH'(1);
            b_ovf <= 1'b0;
            k     <= '0;
            n     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            b_ovf <= b_ovf_nxt;
            k     <= k_nxt;
            n     <= n_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        b_ovf_nxt = b_ovf;
        k_nxt     = k;
        n_nxt     = n;
        ovf_nxt   = ovf;

        // abort outranks both start and the handshake in every state.
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ovf_nxt = 1'b0;
                        if (bus.n_terms != '0) begin
                            state_nxt = RUN;
                            a_nxt     = '0;
                            b_nxt     = WIDTH'(1);
                            b_ovf_nxt = 1'b0;
                            k_nxt     = '0;
                            n_nxt     = bus.n_terms;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (is_last) begin
                            state_nxt = DONE;
                            ovf_nxt   = b_ovf && !at_end;
                        end else begin
                            a_nxt                = b;
                            {b_ovf_nxt, b_nxt}   = sum;
                            k_nxt                = k + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.valid    = (state == RUN);
    assign bus.data     = a;
    assign bus.index    = k;
    assign bus.last     = (state == RUN) && is_last;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.overflow = ovf;
endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Synthesizable, parametrised Fibonacci sequence generator: on a start pulse it streams the first N terms (0, 1, 1, 2, 3, 5, 8, 13, …) one per accepted handshake on a valid/ready output port. It replaces the simulation-only, fixed 8-term/4-bit generator with a clocked block usable in datapath test-pattern and sequence-source roles. It adds run-time term count, output backpressure, synchronous abort and overflow detection.

## Interface
- WIDTH, 16, bit width of each term
- IDX_W, 6, width of term count/index; max N = 2^IDX_W − 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- n_terms  input  IDX_W  number of terms to emit; sampled with start
- abort  input  1  synchronous cancel; returns to IDLE next edge
- ready  input  1  downstream accepts data when valid && ready
- valid  output  1  data/index/last hold a term
- data  output  WIDTH  current term F(index)
- index  output  IDX_W  term number, 0-based
- last  output  1  current term is the final one of the run
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of run
- overflow  output  1  run ended early because F(index+1) exceeds WIDTH; valid with done, held until next start

## Operation
- Reset: state IDLE; valid, last, busy, done, overflow = 0; data, index = 0; internal a = 0, b = 1, b_ovf = 0.
- Internal registers: a = F(k) (driven on data), b = F(k+1), b_ovf = carry out of the WIDTH-bit add that produced b, k = index, n = latched n_terms.
- States: IDLE, RUN, DONE.
- IDLE: on start && n_terms != 0 → RUN; a = 0, b = 1, b_ovf = 0, k = 0, n = n_terms, overflow cleared. On start && n_terms == 0 → DONE; no term emitted, overflow = 0.
- RUN: valid = 1. last = (k == n−1) || b_ovf.
  - Handshake (valid && ready) with !last: a ← b, {b_ovf, b} ← a + b (WIDTH+1-bit sum), k ← k+1.
  - Handshake with last: → DONE; overflow ← b_ovf && (k != n−1).
  - No handshake: data, index, last held stable (no change while valid && !ready).
- DONE: valid = 0; done = 1 for exactly one cycle; → IDLE.
- start while busy: ignored.
- abort in RUN or DONE: → IDLE next edge; valid drops; done not pulsed; overflow unchanged. abort has priority over handshake and start in the same cycle.
- Reaching n_terms exactly when the next term would overflow is not an error (overflow = 0).
- Arithmetic is unsigned modulo 2^WIDTH internally; no wrapped value is ever emitted.

## Timing
- start accepted at edge t → valid = 1 with data = 0, index = 0 after edge t (visible cycle t+1).
- With ready held high: one term per cycle, N terms in cycles t+1 … t+N; done in cycle t+N+1; busy high in cycles t+1 … t+N+1; new start accepted from cycle t+N+2.
- n_terms = 0: done in cycle t+1, busy high that cycle only.
- Each ready-low cycle stretches the run by one cycle; no term dropped or duplicated.
- Outputs are all registered or decoded from registered state only; no combinational path from ready/start to data.
- rst_n assertion mid-run: all outputs reach reset values immediately (asynchronous), independent of clk.

## Test plan
- WIDTH=8, n_terms=8, ready=1: data 0,1,1,2,3,5,8,13 in consecutive cycles, index 0..7, last only on 13, done next cycle, overflow = 0.
- WIDTH=8, n_terms=20: terms up to 233 (index 13, last = 1), then done with overflow = 1; 377 never appears.
- WIDTH=8, n_terms=14: same 14 terms ending at 233, overflow = 0.
- n_terms=10 with ready toggled pseudo-randomly: accepted sequence exactly 0..34; data/index stable whenever valid && !ready; start pulses during run ignored.
- n_terms=0 → done pulse in the next cycle, valid never high; then n_terms=3 → 0,1,1.
- abort at index 4, and separately rst_n low at index 4: valid drops (next edge / immediately), no done pulse; a following start restarts from 0.
